sad_trigger_qualifier: RTL and testbench

SAD_TRIGGER_QUALIFIER -- requirements
Module: sad_trigger_qualifier

---
 rtl/sad_pkg.sv | 22 ++
 rtl/sad_trigger_qualifier.sv | 183 ++++++++++++++++++
 tb/tb_sad_trigger_qualifier.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sad_pkg.sv
// Shared definitions for the SAD trigger path: default widths, FSM state
// encoding and the pulse-width helper used by the trigger qualifier.
package sad_pkg;

  localparam int unsigned SAD_WIDTH_DEF     = 20;
  localparam int unsigned HOLDOFF_WIDTH_DEF = 16;
  localparam int unsigned CNT_WIDTH_DEF     = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_FIRE    = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_DONE    = 3'd4
  } sad_state_e;

  // A programmed width of zero still produces a one-cycle pulse.
  function automatic logic [7:0] eff_width(input logic [7:0] width);
    eff_width = (width == 8'd0) ? 8'd1 : width;
  endfunction

endpackage

// File: rtl/sad_trigger_qualifier.sv
// Qualifies SAD match pulses into a registered capture trigger with pulse
// width, holdoff, single/multi-shot modes and saturating status counters.
module sad_trigger_qualifier
  import sad_pkg::*;
#(
  parameter int unsigned pSAD_WIDTH     = SAD_WIDTH_DEF,
  parameter int unsigned pHOLDOFF_WIDTH = HOLDOFF_WIDTH_DEF,
  parameter int unsigned pCNT_WIDTH     = CNT_WIDTH_DEF
) (
  input  logic                      clk_adc,
  input  logic                      reset_n,
  input  logic                      armed_and_ready,
  input  logic                      match,
  input  logic [pSAD_WIDTH-1:0]     sad_score,
  input  logic                      multiple_triggers,
  input  logic [pHOLDOFF_WIDTH-1:0] holdoff,
  input  logic [7:0]                trigger_width,
  input  logic                      clear_status,
  output logic                      trigger,
  output logic                      triggered,
  output logic [pCNT_WIDTH-1:0]     num_triggers,
  output logic [pCNT_WIDTH-1:0]     ignored_matches,
  output logic [pSAD_WIDTH-1:0]     last_score
);

  localparam logic [pCNT_WIDTH-1:0]     CNT_ONE  = {{(pCNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pCNT_WIDTH-1:0]     CNT_MAX  = {pCNT_WIDTH{1'b1}};
  localparam logic [pHOLDOFF_WIDTH-1:0] HOLD_ONE = {{(pHOLDOFF_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pHOLDOFF_WIDTH-1:0] HOLD_ZERO = {pHOLDOFF_WIDTH{1'b0}};

  sad_state_e                state_q, state_d;
  logic                      arm_prev_q;
  logic [7:0]                fire_cnt_q, fire_cnt_d;
  logic [pHOLDOFF_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic [pHOLDOFF_WIDTH-1:0] cfg_hold_q, cfg_hold_d;
  logic                      cfg_multi_q, cfg_multi_d;
  logic                      trigger_q, trigger_d;
  logic                      triggered_q, triggered_d;
  logic [pCNT_WIDTH-1:0]     num_q, num_d;
  logic [pCNT_WIDTH-1:0]     ign_q, ign_d;
  logic [pSAD_WIDTH-1:0]     last_q, last_d;

  logic                      accept_s;
  logic                      ignore_s;
  logic                      arm_rise_s;
  logic                      clr_s;
  logic [pCNT_WIDTH-1:0]     num_inc_s;
  logic [pCNT_WIDTH-1:0]     ign_inc_s;

  assign arm_rise_s = armed_and_ready & ~arm_prev_q;

  always_comb begin
    state_d     = state_q;
    fire_cnt_d  = fire_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    cfg_hold_d  = cfg_hold_q;
    cfg_multi_d = cfg_multi_q;
    accept_s    = 1'b0;
    ignore_s    = 1'b0;

    // Matches outside ARMED are counted as dropped even while disarming.
    if ((state_q == ST_FIRE) || (state_q == ST_HOLDOFF) || (state_q == ST_DONE)) begin
      ignore_s = match;
    end else begin
      ignore_s = 1'b0;
    end

    if (!armed_and_ready) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (match) begin
            state_d     = ST_FIRE;
            accept_s    = 1'b1;
            fire_cnt_d  = eff_width(trigger_width) - 8'd1;
            cfg_hold_d  = holdoff;
            cfg_multi_d = multiple_triggers;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_FIRE: begin
          if (fire_cnt_q == 8'd0) begin
            if (cfg_hold_q != HOLD_ZERO) begin
              state_d    = ST_HOLDOFF;
              hold_cnt_d = cfg_hold_q - HOLD_ONE;
            end else if (cfg_multi_q) begin
              state_d = ST_ARMED;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            fire_cnt_d = fire_cnt_q - 8'd1;
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt_q == HOLD_ZERO) begin
            state_d = cfg_multi_q ? ST_ARMED : ST_DONE;
          end else begin
            hold_cnt_d = hold_cnt_q - HOLD_ONE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    trigger_d = (state_d == ST_FIRE);
  end

  // An accepted match takes priority over any clear in the same cycle.
  always_comb begin
    clr_s       = clear_status | arm_rise_s;
    num_inc_s   = (num_q == CNT_MAX) ? num_q : (num_q + CNT_ONE);
    ign_inc_s   = (ign_q == CNT_MAX) ? ign_q : (ign_q + CNT_ONE);
    triggered_d = triggered_q;
    num_d       = num_q;
    ign_d       = ign_q;
    last_d      = last_q;

    if (accept_s) begin
      triggered_d = 1'b1;
      num_d       = clr_s ? CNT_ONE : num_inc_s;
      last_d      = sad_score;
    end else if (clr_s) begin
      triggered_d = 1'b0;
      num_d       = {pCNT_WIDTH{1'b0}};
    end else begin
      triggered_d = triggered_q;
    end

    if (ignore_s) begin
      ign_d = clr_s ? CNT_ONE : ign_inc_s;
    end else if (clr_s) begin
      ign_d = {pCNT_WIDTH{1'b0}};
    end else begin
      ign_d = ign_q;
    end
  end

  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      arm_prev_q  <= 1'b0;
      fire_cnt_q  <= 8'd0;
      hold_cnt_q  <= HOLD_ZERO;
      cfg_hold_q  <= HOLD_ZERO;
      cfg_multi_q <= 1'b0;
      trigger_q   <= 1'b0;
      triggered_q <= 1'b0;
      num_q       <= {pCNT_WIDTH{1'b0}};
      ign_q       <= {pCNT_WIDTH{1'b0}};
      last_q      <= {pSAD_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      arm_prev_q  <= armed_and_ready;
      fire_cnt_q  <= fire_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      cfg_hold_q  <= cfg_hold_d;
      cfg_multi_q <= cfg_multi_d;
      trigger_q   <= trigger_d;
      triggered_q <= triggered_d;
      num_q       <= num_d;
      ign_q       <= ign_d;
      last_q      <= last_d;
    end
  end

  assign trigger         = trigger_q;
  assign triggered       = triggered_q;
  assign num_triggers    = num_q;
  assign ignored_matches = ign_q;
  assign last_score      = last_q;

endmodule

// File: tb/tb_sad_trigger_qualifier.sv
// Self-checking bench: directed scenarios plus random traffic compared every
// cycle against a time-window model of the trigger qualifier.
module tb_sad_trigger_qualifier;

  logic        clk_adc = 1'b0;
  logic        reset_n = 1'b0;
  logic        armed_and_ready = 1'b0;
  logic        match = 1'b0;
  logic [19:0] sad_score = 20'd0;
  logic        multiple_triggers = 1'b1;
  logic [15:0] holdoff = 16'd0;
  logic [7:0]  trigger_width = 8'd1;
  logic        clear_status = 1'b0;
  logic        trigger;
  logic        triggered;
  logic [7:0]  num_triggers;
  logic [7:0]  ignored_matches;
  logic [19:0] last_score;

  sad_trigger_qualifier dut (
    .clk_adc           (clk_adc),
    .reset_n           (reset_n),
    .armed_and_ready   (armed_and_ready),
    .match             (match),
    .sad_score         (sad_score),
    .multiple_triggers (multiple_triggers),
    .holdoff           (holdoff),
    .trigger_width     (trigger_width),
    .clear_status      (clear_status),
    .trigger           (trigger),
    .triggered         (triggered),
    .num_triggers      (num_triggers),
    .ignored_matches   (ignored_matches),
    .last_score        (last_score)
  );

  always #5 clk_adc = ~clk_adc;

  int vectors = 0;
  int miscompares = 0;

  // Model: the trigger is high for edges [m_lo, m_hi]; matches are accepted
  // from edge m_accept_from onward while armed and not in single-shot done.
  int          cyc = 0;
  bit          m_idle = 1'b1;
  bit          m_done = 1'b0;
  bit          m_prev_arm = 1'b0;
  int          m_accept_from = 0;
  int          m_lo = 0;
  int          m_hi = -1;
  bit          m_trig = 1'b0;
  bit          m_triggered = 1'b0;
  int          m_num = 0;
  int          m_ign = 0;
  logic [19:0] m_last = 20'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_done = 1'b0; m_prev_arm = 1'b0; m_accept_from = 0;
    m_lo = 0; m_hi = -1; m_trig = 1'b0; m_triggered = 1'b0;
    m_num = 0; m_ign = 0; m_last = 20'd0;
  endtask

  task automatic model_edge();
    bit rise, region, acc, ign, clr;
    int w;
    rise   = armed_and_ready && !m_prev_arm;
    region = !m_idle && !m_done && (cyc >= m_accept_from);
    acc    = match && region && armed_and_ready;
    ign    = match && !m_idle && !region;
    clr    = clear_status || rise;
    if (!armed_and_ready) begin
      m_idle = 1'b1;
      m_hi   = -1;
    end else if (m_idle) begin
      m_idle = 1'b0;
      m_done = 1'b0;
      m_accept_from = cyc + 1;
    end else if (acc) begin
      w = (trigger_width == 8'd0) ? 1 : int'(trigger_width);
      m_lo = cyc;
      m_hi = cyc + w - 1;
      m_accept_from = cyc + w + int'(holdoff) + 1;
      m_done = !multiple_triggers;
    end
    if (acc) begin
      m_triggered = 1'b1;
      m_num  = clr ? 1 : ((m_num < 255) ? m_num + 1 : 255);
      m_last = sad_score;
    end else if (clr) begin
      m_triggered = 1'b0;
      m_num = 0;
    end
    if (ign) m_ign = clr ? 1 : ((m_ign < 255) ? m_ign + 1 : 255);
    else if (clr) m_ign = 0;
    m_trig = (cyc >= m_lo) && (cyc <= m_hi);
    m_prev_arm = armed_and_ready;
    cyc++;
  endtask

  task automatic compare_all();
    check("trigger", 32'(trigger), 32'(m_trig));
    check("triggered", 32'(triggered), 32'(m_triggered));
    check("num_triggers", 32'(num_triggers), 32'(m_num));
    check("ignored_matches", 32'(ignored_matches), 32'(m_ign));
    check("last_score", 32'(last_score), 32'(m_last));
  endtask

  task automatic step(input logic a, input logic m, input logic c);
    logic [31:0] r;
    r = $urandom;
    armed_and_ready = a;
    match = m;
    clear_status = c;
    sad_score = m ? r[19:0] : 20'd0;
    @(posedge clk_adc);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_cycles(input logic a, input int n);
    for (int i = 0; i < n; i++) step(a, 1'b0, 1'b0);
  endtask

  task automatic set_cfg(input logic [7:0] tw, input logic [15:0] ho, input logic mt);
    trigger_width = tw;
    holdoff = ho;
    multiple_triggers = mt;
  endtask

  initial begin
    repeat (2) @(posedge clk_adc);
    #1;
    reset_n = 1'b1;
    compare_all();

    // Width 3, no holdoff, multi-shot.
    set_cfg(8'd3, 16'd0, 1'b1);
    idle_cycles(1'b1, 9);
    step(1'b1, 1'b1, 1'b0);
    idle_cycles(1'b1, 6);

    // Holdoff 20 with a match dropped inside the dead time.
    idle_cycles(1'b0, 2);
    set_cfg(8'd1, 16'd20, 1'b1);
    idle_cycles(1'b1, 9);
    step(1'b1, 1'b1, 1'b0);
    idle_cycles(1'b1, 4);
    step(1'b1, 1'b1, 1'b0);
    idle_cycles(1'b1, 24);
    step(1'b1, 1'b1, 1'b0);
    idle_cycles(1'b1, 25);

    // Single-shot, then disarm/re-arm clears counters.
    idle_cycles(1'b0, 2);
    set_cfg(8'd1, 16'd0, 1'b0);
    idle_cycles(1'b1, 9);
    step(1'b1, 1'b1, 1'b0);
    idle_cycles(1'b1, 39);
    step(1'b1, 1'b1, 1'b0);
    idle_cycles(1'b1, 3);
    idle_cycles(1'b0, 2);
    idle_cycles(1'b1, 3);
    step(1'b1, 1'b1, 1'b0);
    idle_cycles(1'b1, 3);

    // Width 0 behaves as 1; then a width-8 pulse truncated by disarm.
    idle_cycles(1'b0, 1);
    set_cfg(8'd0, 16'd0, 1'b1);
    idle_cycles(1'b1, 3);
    step(1'b1, 1'b1, 1'b0);
    idle_cycles(1'b1, 3);
    set_cfg(8'd8, 16'd0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    idle_cycles(1'b1, 3);
    idle_cycles(1'b0, 3);

    // Clear coinciding with the arming edge.
    step(1'b1, 1'b0, 1'b1);
    idle_cycles(1'b1, 2);

    // Saturation, then clear coinciding with an accepted match.
    set_cfg(8'd1, 16'd0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b1, 1'b0);
      idle_cycles(1'b1, 3);
    end
    step(1'b1, 1'b1, 1'b1);
    idle_cycles(1'b1, 3);

    // Asynchronous reset in the middle of holdoff.
    set_cfg(8'd1, 16'd20, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    idle_cycles(1'b1, 5);
    reset_n = 1'b0;
    armed_and_ready = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk_adc);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    idle_cycles(1'b1, 2);
    step(1'b1, 1'b1, 1'b0);
    idle_cycles(1'b1, 25);

    // Random traffic.
    begin
      logic a;
      a = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 63) == 0) a = ~a;
        if ($urandom_range(0, 49) == 0)
          set_cfg(8'($urandom_range(0, 4)), 16'($urandom_range(0, 8)), 1'($urandom_range(0, 1)));
        step(a, ($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
